// File: rtl/uart_send.sv
// uart_send: 8N1 UART transmitter, LSB first, valid/ready byte input with a one-byte holding register.
// Define UART_TX_PARITY_EN to add a parity bit after the data (even, or odd when PARITY_ODD=1).
module uart_send #(
    parameter int CLK_FREQ   = 50000000,
    parameter int UART_BPS   = 9600,
    parameter int PARITY_ODD = 0
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       uart_txd,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int          BPS_CNT  = CLK_FREQ / UART_BPS;
    localparam logic [15:0] BPS_LAST = 16'(BPS_CNT - 1);

    if (BPS_CNT < 2 || BPS_CNT > 65535 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_send: BPS_CNT must be 2..65535 and PARITY_ODD 0 or 1");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_e;

`ifdef UART_TX_PARITY_EN
    function automatic logic parity_bit(input logic [7:0] data);
        return (^data) ^ (PARITY_ODD != 0);
    endfunction
`endif

    state_e      state_q, state_d;
    logic [15:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic        txd_q, txd_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        bit_end_s;
    logic        shift_free_s;
    logic        accept_s;
    logic        transfer_s;

    // Next-state, bit timer and holding-register control
    always_comb begin
        bit_end_s    = (clk_cnt_q == BPS_LAST);
        // The shift register is reusable on the very edge that ends STOP.
        shift_free_s = (state_q == S_IDLE) || ((state_q == S_STOP) && bit_end_s);
        accept_s     = tx_valid && !hold_full_q;
        transfer_s   = (state_q == S_STOP) && bit_end_s && hold_full_q;

        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        done_d      = 1'b0;

        if (state_q == S_IDLE) begin
            clk_cnt_d = 16'd0;
        end else if (bit_end_s) begin
            clk_cnt_d = 16'd0;
        end else begin
            clk_cnt_d = clk_cnt_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_START;
                    shift_d = tx_data;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (bit_end_s && (bit_idx_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end else if (bit_end_s) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end_s) begin
                    state_d = S_STOP;
                end else begin
                    state_d = S_PARITY;
                end
            end
`endif
            S_STOP: begin
                if (bit_end_s) begin
                    done_d = 1'b1;
                    if (hold_full_q) begin
                        state_d = S_START;
                        shift_d = hold_q;
                    end else if (accept_s) begin
                        state_d = S_START;
                        shift_d = tx_data;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept_s && !shift_free_s) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end else if (transfer_s) begin
            hold_full_d = 1'b0;
        end else begin
            hold_full_d = hold_full_q;
        end
    end

    // Line level and busy flag decoded from the next state so they appear one cycle after the edge
    always_comb begin
        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_IDLE:   txd_d = 1'b1;
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd_d = parity_bit(shift_d);
`endif
            S_STOP:   txd_d = 1'b1;
            default:  txd_d = 1'b1;
        endcase
    end

    // State and output registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= S_IDLE;
            clk_cnt_q   <= 16'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'd0;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            txd_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            txd_q       <= txd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign tx_ready = !hold_full_q;
    assign uart_txd = txd_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_send.sv
// tb_uart_send: randomized bench for uart_send against a frame-level queue model.
// Honours UART_TX_PARITY_EN when the design is built with it.
module tb_uart_send;

    localparam int BPS     = 10;
    localparam int DEF_BPS = 5208;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * BPS;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready, uart_txd, tx_busy, tx_done;
    logic       tx_ready_odd, uart_txd_odd, tx_busy_odd, tx_done_odd;
    logic       def_valid;
    logic [7:0] def_data;
    logic       def_ready, def_txd, def_busy, def_done;

    always #5 sys_clk = ~sys_clk;

    uart_send #(.CLK_FREQ(1000000), .UART_BPS(100000), .PARITY_ODD(0)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .uart_txd(uart_txd), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    uart_send #(.CLK_FREQ(1000000), .UART_BPS(100000), .PARITY_ODD(1)) dut_odd (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready_odd), .uart_txd(uart_txd_odd), .tx_busy(tx_busy_odd), .tx_done(tx_done_odd)
    );

    uart_send dut_def (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_valid(def_valid), .tx_data(def_data),
        .tx_ready(def_ready), .uart_txd(def_txd), .tx_busy(def_busy), .tx_done(def_done)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: bytes owned by the transmitter (line byte first) and cycles left in the current frame
    logic [7:0] mq[$];
    int         rem    = 0;
    logic       m_done = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        rem    = 0;
        m_done = 1'b0;
    endfunction

    function automatic void model_edge();
        logic acc;
        if (sys_rst) begin
            model_reset();
            return;
        end
        acc    = tx_valid && (mq.size() < 2);
        m_done = 1'b0;
        if (rem > 0) begin
            rem--;
            if (rem == 0) begin
                void'(mq.pop_front());
                m_done = 1'b1;
                if (mq.size() > 0) rem = FRAME;
            end
        end
        if (acc) begin
            mq.push_back(tx_data);
            if (rem == 0) rem = FRAME;
        end
    endfunction

    function automatic logic exp_txd(input logic odd);
        int k;
        logic [7:0] d;
        if (rem == 0) return 1'b1;
        d = mq[0];
        k = (FRAME - rem) / BPS;
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (NBITS == 11 && k == 9) return (^d) ^ odd;
        return 1'b1;
    endfunction

    task automatic compare_outputs();
        check_eq("txd",      32'(uart_txd),     32'(exp_txd(1'b0)));
        check_eq("txd_odd",  32'(uart_txd_odd), 32'(exp_txd(1'b1)));
        check_eq("busy",     32'(tx_busy),      32'(rem > 0));
        check_eq("busy_odd", 32'(tx_busy_odd),  32'(rem > 0));
        check_eq("ready",    32'(tx_ready),     32'(mq.size() < 2));
        check_eq("done",     32'(tx_done),      32'(m_done));
        check_eq("done_odd", 32'(tx_done_odd),  32'(m_done));
    endtask

    task automatic tick();
        @(posedge sys_clk);
        model_edge();
        #1;
        cyc++;
        compare_outputs();
    endtask

    initial begin
        int t_low, t_done, dones, low, high, busy_cnt, d1, d2;

        sys_rst   = 1'b1;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        def_valid = 1'b0;
        def_data  = 8'h00;
        model_reset();
        repeat (3) tick();
        check_eq("rst_def_txd",   32'(def_txd),   32'd1);
        check_eq("rst_def_busy",  32'(def_busy),  32'd0);
        check_eq("rst_def_ready", 32'(def_ready), 32'd1);
        check_eq("rst_def_done",  32'(def_done),  32'd0);
        #2 sys_rst = 1'b0;
        repeat (2) tick();

        // Single byte 0x55
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        tick();
        tx_valid = 1'b0;
        t_low = -1; t_done = -1; dones = 0;
        if (!uart_txd) t_low = cyc;
        for (int c = 0; c < FRAME + 10; c++) begin
            tick();
            if (!uart_txd && t_low < 0) t_low = cyc;
            if (tx_done) begin dones++; t_done = cyc; end
        end
        check_eq("t1_done_count", 32'(dones), 32'd1);
        check_eq("t1_low_to_done", 32'(t_done - t_low), 32'(FRAME));

        // Back-to-back 0xA5 then 0x3C, data scrambled while not accepted
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        tick();
        tx_data  = 8'h3C;
        tick();
        tx_valid = 1'b0;
        check_eq("t2_ready_low", 32'(tx_ready), 32'd0);
        d1 = -1; d2 = -1;
        for (int c = 0; c < 2 * FRAME + 10; c++) begin
            tx_data = 8'($urandom);
            tick();
            if (tx_done && d1 < 0) d1 = cyc;
            else if (tx_done && d2 < 0) d2 = cyc;
        end
        check_eq("t2_done_gap", 32'(d2 - d1), 32'(FRAME));

        // Reset during data bit 3 with a byte held
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        tick();
        tx_data  = 8'h3C;
        tick();
        tx_valid = 1'b0;
        repeat (BPS + 3 * BPS + BPS / 2 - 1) tick();
        #2 sys_rst = 1'b1;
        #1;
        model_reset();
        check_eq("t4_txd",   32'(uart_txd), 32'd1);
        check_eq("t4_busy",  32'(tx_busy),  32'd0);
        check_eq("t4_ready", 32'(tx_ready), 32'd1);
        compare_outputs();
        repeat (2) tick();
        #2 sys_rst = 1'b0;
        tick();
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        tick();
        tx_valid = 1'b0;
        low = 0; dones = 0;
        if (!uart_txd) low++;
        for (int c = 0; c < FRAME + 10; c++) begin
            tick();
            if (tx_busy && !uart_txd) low++;
            if (tx_done) dones++;
        end
        // 0xFF has even parity 0, so a parity frame carries a second low bit
        check_eq("t4_low_cycles", 32'(low), 32'((NBITS == 11) ? 2 * BPS : BPS));
        check_eq("t4_done_count", 32'(dones), 32'd1);

        // Dense random traffic: data changes every cycle, mostly valid
        for (int c = 0; c < 2500; c++) begin
            tx_valid = ($urandom_range(0, 3) != 0);
            tx_data  = 8'($urandom);
            tick();
        end
        // Sparse random traffic: frames start from idle
        for (int c = 0; c < 2000; c++) begin
            tx_valid = ($urandom_range(0, 119) == 0);
            tx_data  = 8'($urandom);
            tick();
        end
        tx_valid = 1'b0;
        repeat (2 * FRAME + 5) tick();

        // Default rate: 0x00 on the 5208-clocks-per-bit instance
        def_valid = 1'b1;
        def_data  = 8'h00;
        tick();
        def_valid = 1'b0;
        def_data  = 8'hFF;
        check_eq("t6_start_latency", 32'(def_txd), 32'd0);
        low = 0; high = 0; busy_cnt = 0; dones = 0;
        if (def_busy) begin busy_cnt++; low++; end
        for (int c = 0; c < NBITS * DEF_BPS + 20; c++) begin
            tick();
            if (def_busy) begin
                busy_cnt++;
                if (def_txd) high++;
                else low++;
            end
            if (def_done) dones++;
        end
        check_eq("t6_low_cycles",  32'(low),      32'((NBITS - 1) * DEF_BPS));
        check_eq("t6_stop_cycles", 32'(high),     32'(DEF_BPS));
        check_eq("t6_frame",       32'(busy_cnt), 32'(NBITS * DEF_BPS));
        check_eq("t6_done_count",  32'(dones),    32'd1);
        check_eq("t6_idle_txd",    32'(def_txd),  32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_send.md
# uart_send

UART transmitter that serialises bytes onto `uart_txd` as 8N1 frames (optional parity), LSB first, at `UART_BPS`. It is the transmit-side counterpart of the UART receiver in the same UART/VGA debugger path. Bytes arrive through a valid/ready handshake. A one-byte holding register behind the shift register lets back-to-back bytes go out with no idle gap between frames.

## Interface
- `CLK_FREQ`, default 50000000: system clock frequency in Hz.
- `UART_BPS`, default 9600: line bit rate.
- `BPS_CNT`, localparam = `CLK_FREQ/UART_BPS` (integer division): clocks per bit; must lie in 2..65535.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd; used only when the parity macro is defined.
- `sys_clk`  in  1: system clock; all logic is on its rising edge.
- `sys_rst`  in  1: asynchronous, active-high reset.
- `tx_valid`  in  1: `tx_data` is offered for transmission.
- `tx_data`  in  8: byte to send; sampled only on the accept edge.
- `tx_ready`  out  1: high when the block can accept a byte (holding register empty).
- `uart_txd`  out  1: serial line; idles high; registered output.
- `tx_busy`  out  1: high while a frame is on the line (state not IDLE).
- `tx_done`  out  1: one-cycle pulse when a frame's stop bit completes.

## Operation
- **Accept:** an accept occurs on any edge with `tx_valid && tx_ready`.
  - If the shift register is free (IDLE, or the last cycle of STOP), the byte loads straight into the shift register.
  - Otherwise the byte loads into the holding register and `tx_ready` drops.
- **FSM states:** IDLE, START, DATA, PARITY (only with the macro), STOP.
- **Bit timer:** 16-bit `clk_cnt` counts 0..`BPS_CNT-1` in every non-IDLE state and wraps to 0 at each bit boundary. Each bit lasts exactly `BPS_CNT` cycles.
- **DATA:** 3-bit bit index 0..7; `uart_txd` = `shift[idx]`, LSB first.
- **Transitions:**
  - IDLE→START on accept.
  - START→DATA at the bit boundary.
  - DATA→(PARITY|STOP) after bit 7.
  - PARITY→STOP at the bit boundary.
  - At the STOP boundary: go to START if the holding register is full or an accept happens on that edge; otherwise go to IDLE.
- **End of STOP with holding register full:** the holding register transfers to the shift register and `tx_ready` rises on the same edge.
- **Stability:** `tx_data` may change freely when no accept occurs. Only accepted values are transmitted.

## Timing
- **Reset values:** `uart_txd`=1, `tx_busy`=0, `tx_done`=0, `tx_ready`=1, state IDLE, `clk_cnt`=0, holding register empty.
- **Start latency:** `uart_txd` goes low in the cycle after the accept edge (1-cycle latency).
- **Frame length:** 10·`BPS_CNT` cycles, or 11·`BPS_CNT` with parity. `tx_busy` is high for exactly that long per frame.
- **`tx_done`:** high for the one cycle following the final STOP edge.
- **Back-to-back:** the next start bit begins on the same edge that ends STOP. There is zero idle cycles between frames, and `tx_done` still pulses.
- **Reset mid-frame:** all outputs return to reset values immediately (asynchronously). The frame in progress and the held byte are discarded.

## Configuration
- `UART_TX_PARITY_EN`:
  - **Defined:** the PARITY state is inserted after DATA and carries `^shift[7:0] ^ PARITY_ODD`; frames are 11 bits.
  - **Undefined:** there is no PARITY state, frames are 10 bits, and `PARITY_ODD` has no effect.

## Test plan
- **T1 single byte:** `CLK_FREQ`=1000000, `UART_BPS`=100000 (`BPS_CNT`=10). After reset, send 0x55.
  - `uart_txd` shows 0,1,0,1,0,1,0,1,0,1, each bit 10 cycles.
  - `tx_busy` is high for 100 cycles; `tx_done` pulses once, 100 cycles after the low edge.
- **T2 back-to-back:** hold `tx_valid` with 0xA5, then 0x3C.
  - 0x3C is accepted during frame 1, after which `tx_ready` stays low until frame 1's STOP ends.
  - Frames are contiguous (200 cycles), with two `tx_done` pulses 100 cycles apart.
- **T3 parity** (macro defined): send 0x07.
  - With `PARITY_ODD`=0 the parity bit is 1; with `PARITY_ODD`=1 it is 0.
  - The frame is 110 cycles; the stop bit is 1.
- **T4 reset mid-frame:** assert `sys_rst` during data bit 3.
  - `uart_txd`=1, `tx_busy`=0 and `tx_ready`=1 immediately.
  - After release, 0xFF is sent as a clean 0 followed by nine 1s.
- **T5 handshake integrity:** toggle `tx_data` every cycle while `tx_ready`=0. Only the bytes present on accept edges appear on the line.
- **T6 default rate:** default parameters (`BPS_CNT`=5208). Every bit of 0x00 measures exactly 5208 cycles, and the frame is 52080 cycles.
